// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : Serial line, oversampling strobe and received-word signals of the UART receiver.
// Revision : 1.0
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_WD = 8
);
    logic               rx;
    logic               tick;
    logic [DATA_WD-1:0] dout;
    logic               rx_done;
    logic               rx_busy;
    logic               parity_err;
    logic               frame_err;

    // The receiver is the slave; whoever drives the line and the baud strobe is the master.
    modport slave (
        input  rx,
        input  tick,
        output dout,
        output rx_done,
        output rx_busy,
        output parity_err,
        output frame_err
    );

    modport master (
        output rx,
        output tick,
        input  dout,
        input  rx_done,
        input  rx_busy,
        input  parity_err,
        input  frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver; centre-samples each bit and reports parity/framing errors.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int BAUD              = 9600,
    parameter int CLK_FREQ          = 50_000_000,
    parameter int OVERSAMPLING_RATE = 16,
    parameter int DATA_WD           = 8,
    parameter int PARITY            = 0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    uart_rx_if.slave  bus
);

    localparam int c_CNT_W = $clog2(OVERSAMPLING_RATE);
    localparam int c_IDX_W = $clog2(DATA_WD) + 1;
    localparam bit c_PAR_EN = (PARITY == 1) || (PARITY == 2);
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(OVERSAMPLING_RATE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(OVERSAMPLING_RATE - 1);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(DATA_WD - 1);

    if (OVERSAMPLING_RATE < 4 || (OVERSAMPLING_RATE % 2) != 0 ||
        (CLK_FREQ / BAUD) < OVERSAMPLING_RATE) begin : g_bad_params
        $error("uart_rx: oversampling rate must be even, >= 4 and reachable from the clock");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state,      w_state_nxt;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [c_CNT_W-1:0]   r_tick_count, w_tick_count;
    logic [c_IDX_W-1:0]   r_bit_index,  w_bit_index;
    logic [DATA_WD-1:0]   r_shift,      w_shift;
    logic                 r_par_bit,    w_par_bit;
    logic                 r_break,      w_break;
    logic [DATA_WD-1:0]   r_dout,       w_dout;
    logic                 r_done,       w_done;
    logic                 r_busy,       w_busy;
    logic                 r_perr,       w_perr;
    logic                 r_ferr,       w_ferr;
    logic                 w_par_exp;

    // Odd setting expects the XOR of the data, even setting its complement.
    assign w_par_exp = (PARITY == 1) ? (^r_shift) : ~(^r_shift);

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_count = r_tick_count;
        w_bit_index  = r_bit_index;
        w_shift      = r_shift;
        w_par_bit    = r_par_bit;
        w_break      = r_break;
        w_dout       = r_dout;
        w_done       = 1'b0;
        w_busy       = r_busy;
        w_perr       = r_perr;
        w_ferr       = r_ferr;

        case (r_state)
            S_IDLE: begin
                w_tick_count = '0;
                // After a low stop bit the line must go idle before a new start is accepted.
                if (r_rx_s) begin
                    w_break = 1'b0;
                end
                if (bus.tick && !r_rx_s && !r_break) begin
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                if (bus.tick) begin
                    if (r_tick_count == c_HALF) begin
                        w_tick_count = '0;
                        if (!r_rx_s) begin
                            w_busy      = 1'b1;
                            w_bit_index = '0;
                            w_state_nxt = S_DATA;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_tick_count = r_tick_count + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (bus.tick) begin
                    if (r_tick_count == c_FULL) begin
                        w_tick_count = '0;
                        w_shift      = {r_rx_s, r_shift[DATA_WD-1:1]};
                        w_bit_index  = r_bit_index + 1'b1;
                        if (r_bit_index == c_LAST) begin
                            w_state_nxt = c_PAR_EN ? S_PARITY : S_STOP;
                        end
                    end else begin
                        w_tick_count = r_tick_count + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (bus.tick) begin
                    if (r_tick_count == c_FULL) begin
                        w_tick_count = '0;
                        w_par_bit    = r_rx_s;
                        w_state_nxt  = S_STOP;
                    end else begin
                        w_tick_count = r_tick_count + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (bus.tick) begin
                    if (r_tick_count == c_FULL) begin
                        w_tick_count = '0;
                        w_dout       = r_shift;
                        w_ferr       = ~r_rx_s;
                        w_perr       = c_PAR_EN ? (r_par_bit != w_par_exp) : 1'b0;
                        w_done       = 1'b1;
                        w_busy       = 1'b0;
                        w_break      = ~r_rx_s;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_tick_count = r_tick_count + 1'b1;
                    end
                end
            end

            default: begin
                w_tick_count = '0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_state      <= S_IDLE;
            r_tick_count <= '0;
            r_bit_index  <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_break      <= 1'b0;
            r_dout       <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
        end else begin
            r_rx_meta    <= bus.rx;
            r_rx_s       <= r_rx_meta;
            r_state      <= w_state_nxt;
            r_tick_count <= w_tick_count;
            r_bit_index  <= w_bit_index;
            r_shift      <= w_shift;
            r_par_bit    <= w_par_bit;
            r_break      <= w_break;
            r_dout       <= w_dout;
            r_done       <= w_done;
            r_busy       <= w_busy;
            r_perr       <= w_perr;
            r_ferr       <= w_ferr;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.rx_done    = r_done;
    assign bus.rx_busy    = r_busy;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed and random frames into a no-parity and an odd-parity receiver.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int OSR          = 16;
    localparam int DW           = 8;
    localparam int CLK_PER_TICK = 4;
    localparam int BIT_CLKS     = OSR * CLK_PER_TICK;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        logic          busy;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tick  = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic busy_seen0 = 1'b0;
    rec_t got0[$];
    rec_t got1[$];
    rec_t exp0[$];
    rec_t exp1[$];

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WD(DW)) if0 ();
    uart_rx_if #(.DATA_WD(DW)) if1 ();

    assign if0.tick = tick;
    assign if1.tick = tick;

    uart_rx #(.OVERSAMPLING_RATE(OSR), .DATA_WD(DW), .PARITY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    uart_rx #(.OVERSAMPLING_RATE(OSR), .DATA_WD(DW), .PARITY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    initial begin
        forever begin
            repeat (CLK_PER_TICK - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (if0.rx_busy) busy_seen0 = 1'b1;
        if (if0.rx_done) got0.push_back({if0.dout, if0.parity_err, if0.frame_err, if0.rx_busy});
        if (if1.rx_done) got1.push_back({if1.dout, if1.parity_err, if1.frame_err, if1.rx_busy});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int u, input logic b, input int clks);
        if (u == 0) if0.rx = b;
        else        if1.rx = b;
        repeat (clks) @(negedge clk);
    endtask

    // Reference: a frame yields its data word, odd-parity error if the parity bit
    // differs from the XOR of the data, framing error if the stop bit is low.
    task automatic send(input int u, input logic [DW-1:0] d, input logic pbit, input logic stop);
        logic busy;
        drive(u, 1'b0, BIT_CLKS);
        drive(u, d[0], BIT_CLKS / 2);
        busy = (u == 0) ? if0.rx_busy : if1.rx_busy;
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        repeat (BIT_CLKS - BIT_CLKS / 2) @(negedge clk);
        for (int i = 1; i < DW; i++) drive(u, d[i], BIT_CLKS);
        if (u == 1) drive(u, pbit, BIT_CLKS);
        drive(u, stop, BIT_CLKS);
        if (u == 0) exp0.push_back({d, 1'b0, ~stop, 1'b0});
        else        exp1.push_back({d, (pbit != (^d)), ~stop, 1'b0});
    endtask

    task automatic compare_q(input int u, input string tag);
        rec_t gq[$];
        rec_t eq[$];
        rec_t g;
        rec_t e;
        repeat (16) @(negedge clk);
        if (u == 0) begin gq = got0; eq = exp0; got0.delete(); exp0.delete(); end
        else        begin gq = got1; eq = exp1; got1.delete(); exp1.delete(); end
        check({tag, "_count"}, gq.size(), eq.size());
        while (gq.size() > 0 && eq.size() > 0) begin
            g = gq.pop_front();
            e = eq.pop_front();
            check({tag, "_dout"}, {24'd0, g.data}, {24'd0, e.data});
            check({tag, "_perr"}, {31'd0, g.perr}, {31'd0, e.perr});
            check({tag, "_ferr"}, {31'd0, g.ferr}, {31'd0, e.ferr});
            check({tag, "_busy"}, {31'd0, g.busy}, {31'd0, e.busy});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout0"}, {24'd0, if0.dout}, 32'd0);
        check({tag, "_flags0"}, {28'd0, if0.rx_done, if0.rx_busy, if0.parity_err, if0.frame_err}, 32'd0);
        check({tag, "_dout1"}, {24'd0, if1.dout}, 32'd0);
        check({tag, "_flags1"}, {28'd0, if1.rx_done, if1.rx_busy, if1.parity_err, if1.frame_err}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          p;

        if0.rx = 1'b1;
        if1.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);

        send(0, 8'hA5, 1'b0, 1'b1);
        compare_q(0, "a5");

        send(1, 8'h37, 1'b1, 1'b1);
        send(1, 8'h37, 1'b0, 1'b1);
        compare_q(1, "par37");

        // Start glitch shorter than half a bit
        busy_seen0 = 1'b0;
        drive(0, 1'b0, 4 * CLK_PER_TICK);
        drive(0, 1'b1, 2 * BIT_CLKS);
        check("glitch_busy", {31'd0, busy_seen0}, 32'd0);
        compare_q(0, "glitch");
        send(0, 8'h3C, 1'b0, 1'b1);
        compare_q(0, "after_glitch");

        // Break: stop bit low and line held low for 20 bit periods
        send(0, 8'h55, 1'b0, 1'b0);
        drive(0, 1'b0, 20 * BIT_CLKS);
        drive(0, 1'b1, 2 * BIT_CLKS);
        compare_q(0, "break");
        send(0, 8'h81, 1'b0, 1'b1);
        compare_q(0, "after_break");

        // Reset in the middle of data bit 3 of 0xFF
        drive(0, 1'b0, BIT_CLKS);
        drive(0, 1'b1, 3 * BIT_CLKS + BIT_CLKS / 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        drive(0, 1'b1, 8 * BIT_CLKS);
        compare_q(0, "mid_reset");
        send(0, 8'h12, 1'b0, 1'b1);
        compare_q(0, "after_reset");

        send(0, 8'h00, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b1);
        send(0, 8'h5A, 1'b0, 1'b1);
        compare_q(0, "b2b");

        for (int i = 0; i < 6; i++) begin
            d = DW'($urandom);
            send(0, d, 1'b0, 1'b1);
        end
        compare_q(0, "rand0");

        for (int i = 0; i < 6; i++) begin
            d = DW'($urandom);
            p = 1'($urandom_range(0, 1));
            send(1, d, p, 1'b1);
        end
        compare_q(1, "rand1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive half of the UART IP. It shares the baud generator `tick` with the transmitter and uses the same frame format. The format is start bit, `data_wd` data bits LSB first, an optional parity bit, and one stop bit. It oversamples the line, samples each bit at its centre, and presents one parallel word per frame with a single-cycle `rx_done` strobe and parity/framing error flags.

## Interface
- `BAUD`, 9600: line baud rate; informational only, the timing comes from `tick`.
- `clk_freq`, 50_000_000: system clock frequency in Hz; informational only.
- `oversampling_rate`, 16: `tick` pulses per bit period; must be even and ≥ 4.
- `data_wd`, 8: data bits per frame.
- `parity`, 0: 1 = odd setting (expected bit = XOR of data), 2 = even setting (expected bit = XNOR of data), any other value = no parity bit.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `tick` input 1: oversampling strobe, one `clk` wide, from the baud generator.
- `dout` output `data_wd`: received word, held until the next frame completes.
- `rx_done` output 1: one-cycle pulse when a frame completes (good or bad).
- `rx_busy` output 1: high from a confirmed start bit until the frame completes.
- `parity_err` output 1: parity mismatch on the last frame; valid from `rx_done`, held until the next `rx_done`.
- `frame_err` output 1: stop bit sampled low on the last frame; same validity as `parity_err`.

## Operation
- `rx` passes through a 2-flop synchronizer; reset value of both flops is 1. All logic below uses the synchronized value `rx_s`.
- Internal counters:
  - `tick_count`, width $clog2(oversampling_rate), advances only on `tick`.
  - `bit_index`, width $clog2(data_wd)+1.
  - A shift register of `data_wd` bits.
- IDLE: `tick_count` is held at 0. A low `rx_s` sampled on `tick` goes to START, with `tick_count` set to 0.
- START: on each `tick`, increment `tick_count`. At `tick_count == oversampling_rate/2-1`, re-check `rx_s`:
  - if `rx_s` is 0: start is confirmed. Set `rx_busy` to 1, clear `tick_count` and `bit_index`, go to DATA.
  - if `rx_s` is 1: treat it as a glitch. Return to IDLE with no outputs changed.
- DATA: at `tick_count == oversampling_rate-1` (bit centre):
  - shift `rx_s` into the MSB, shifting right so the first received bit lands in bit 0;
  - increment `bit_index` and clear `tick_count`.
  - After bit `data_wd-1`, go to PARITY if parity is enabled, otherwise STOP.
- PARITY: at bit centre, capture `rx_s` as `par_bit`, then go to STOP.
- STOP: at bit centre, in one `clk` cycle:
  - `dout` is loaded from the shift register;
  - `frame_err` is set to `~rx_s`;
  - `parity_err` is set to (`par_bit` != expected) when parity is enabled, otherwise 0;
  - `rx_done` pulses to 1 and `rx_busy` goes to 0;
  - the FSM returns to IDLE.
- If the stop bit is low (`frame_err`), IDLE waits for `rx_s` to return to 1 before arming a new start detect. A break condition therefore produces exactly one frame.
- A frame with errors still updates `dout`; downstream logic decides whether to discard it.
- An async reset asserted mid-frame forces the FSM to IDLE, clears all counters, and sets every output to its reset value on the next observable edge. A partial frame never raises `rx_done`.
- When `tick` and reset act together, reset wins. `tick` has no effect outside its strobe cycle.

## Timing
- Reset values:
  - `dout` = 0, `rx_done` = 0, `rx_busy` = 0, `parity_err` = 0, `frame_err` = 0;
  - FSM in IDLE, counters at 0.
- Synchronizer latency: 2 `clk` cycles from `rx` to `rx_s`.
- Start detection happens on the first `tick` that sees `rx_s` low. `rx_busy` rises on the `tick` half a bit later.
- Every data, parity, and stop sample falls 8 ticks (the bit centre) after its edge at the default oversampling.
- `rx_done` asserts in the `clk` cycle after the stop-bit centre `tick`, for exactly one cycle. `dout` and the error flags are stable in that same cycle.
- Minimum spacing between start edges is (1 + `data_wd` + parity + 0.5) bit periods. Back-to-back frames with a full one-bit stop are received without loss.
- No backpressure: a consumer that misses `rx_done` loses the word when the next frame overwrites it.

## Test plan
- Default parameters, send 0xA5 at a 16-tick bit period → `dout` = 0xA5, one `rx_done` pulse, `parity_err` = 0, `frame_err` = 0, `rx_busy` low after the pulse.
- `parity` = 1, send 0x37 with parity bit 1 (XOR of 0x37 = 1) → `parity_err` = 0. Repeat with parity bit 0 → `dout` = 0x37, `parity_err` = 1.
- Pull `rx` low for 4 ticks, then high → no `rx_busy`, no `rx_done`, FSM back in IDLE. Then send 0x3C → `dout` = 0x3C.
- Send 0x55 with the stop bit held low, then release `rx` after 20 bit periods → exactly one `rx_done`, `frame_err` = 1, no second frame. Then send 0x81 → `frame_err` = 0, `dout` = 0x81.
- Assert `rst` low during bit 3 of 0xFF → all outputs return to their reset values, no `rx_done`. Then send 0x12 → `dout` = 0x12.
- Send 0x00, 0xFF, 0x5A back-to-back with one stop bit each → three `rx_done` pulses in order with matching `dout` and no error flags.
